// File: rtl/branch_predict_ctrl_pkg.sv
// Shared encodings for the branch predictor: branch/jump type codes,
// 2-bit BHT counter states and the saturating counter update.
package branch_predict_ctrl_pkg;

    typedef enum logic [2:0] {
        BJ_NO   = 3'd0,
        BJ_J    = 3'd1,
        BJ_BEQ  = 3'd2,
        BJ_BNE  = 3'd3,
        BJ_BLT  = 3'd4,
        BJ_BGE  = 3'd5,
        BJ_BLTU = 3'd6,
        BJ_BGEU = 3'd7
    } bj_type_e;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bht_ctr_e;

    localparam bht_ctr_e BHT_RESET = WNT;

    function automatic logic is_cond_branch(input logic [2:0] bj);
        return (bj != BJ_NO) && (bj != BJ_J);
    endfunction

    function automatic logic [1:0] bht_sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != ST) begin
            res = ctr + 2'd1;
        end else if (!taken && ctr != SNT) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_bht.sv
// Bimodal branch history table: 2^IDX_BITS two-bit saturating counters,
// asynchronous clear, one combinational read port and one update port.
module branch_predict_ctrl_bht
    import branch_predict_ctrl_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output logic [1:0]          rd_ctr_o,
    input  logic                wr_en_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic                wr_taken_i
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d [ENTRIES];

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        assign ctr_d[gi] = (wr_en_i && wr_idx_i == IDX_BITS'(gi))
                         ? bht_sat_update(ctr_q[gi], wr_taken_i)
                         : ctr_q[gi];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BHT_RESET;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

    // Read sees the pre-update value when it hits the entry being trained.
    assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction and PC-redirect control: ID-stage bimodal prediction,
// EX-stage mispredict recovery, BHT training and performance counters.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        STALL,
    input  logic [2:0]  ID_BRANCH_JUMP,
    input  logic [31:0] ID_PC,
    input  logic [31:0] ID_TARGET,
    input  logic [2:0]  EX_BRANCH_JUMP,
    input  logic [31:0] EX_PC,
    input  logic [31:0] EX_TARGET,
    input  logic        EX_PRED_TAKEN,
    input  logic        EX_PC_SEL,
    output logic        ID_PRED_TAKEN,
    output logic        REDIRECT,
    output logic [31:0] REDIRECT_PC,
    output logic        FLUSH_IF_ID,
    output logic        FLUSH_ID_EX,
    output logic [31:0] BRANCH_COUNT,
    output logic [31:0] MISPREDICT_COUNT
);

    logic [1:0]  id_ctr;
    logic        ex_valid;
    logic        ex_mispredict;
    logic        bht_wr_en;
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    branch_predict_ctrl_bht #(
        .IDX_BITS (IDX_BITS)
    ) u_bht (
        .clk_i      (CLK),
        .rst_ni     (RESET_N),
        .rd_idx_i   (ID_PC[IDX_BITS+1:2]),
        .rd_ctr_o   (id_ctr),
        .wr_en_i    (bht_wr_en),
        .wr_idx_i   (EX_PC[IDX_BITS+1:2]),
        .wr_taken_i (EX_PC_SEL)
    );

    assign ID_PRED_TAKEN = (ID_BRANCH_JUMP == BJ_J)
                         || (is_cond_branch(ID_BRANCH_JUMP) && id_ctr[1]);

    assign ex_valid      = (EX_BRANCH_JUMP != BJ_NO);
    assign ex_mispredict = ex_valid && (EX_PRED_TAKEN != EX_PC_SEL);
    assign bht_wr_en     = !STALL && is_cond_branch(EX_BRANCH_JUMP);

    // EX is the older instruction, so its recovery beats an ID redirect.
    always_comb begin
        REDIRECT    = 1'b0;
        REDIRECT_PC = 32'd0;
        FLUSH_IF_ID = 1'b0;
        FLUSH_ID_EX = 1'b0;
        if (ex_mispredict) begin
            REDIRECT    = 1'b1;
            REDIRECT_PC = EX_PC_SEL ? EX_TARGET : EX_PC + 32'd4;
            FLUSH_IF_ID = 1'b1;
            FLUSH_ID_EX = 1'b1;
        end else if (ID_PRED_TAKEN) begin
            REDIRECT    = 1'b1;
            REDIRECT_PC = ID_TARGET;
            FLUSH_IF_ID = 1'b1;
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (!STALL) begin
            if (ex_valid) begin
                branch_cnt_d = branch_cnt_q + 32'd1;
            end
            if (ex_mispredict) begin
                mispred_cnt_d = mispred_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            branch_cnt_q  <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BRANCH_COUNT     = branch_cnt_q;
    assign MISPREDICT_COUNT = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural predictor model.
module tb_branch_predict_ctrl;
    import branch_predict_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [2:0]  id_bj;
    logic [31:0] id_pc, id_tgt;
    logic [2:0]  ex_bj;
    logic [31:0] ex_pc, ex_tgt;
    logic        ex_pred, ex_sel;
    logic        id_pred_taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_if_id, flush_id_ex;
    logic [31:0] branch_count, mispredict_count;

    int          n_checks;
    int          n_pass;
    int          n_txn;

    int          bht_m [64];
    logic [31:0] bcnt_m, mcnt_m;

    branch_predict_ctrl #(
        .IDX_BITS (6)
    ) dut (
        .CLK              (clk),
        .RESET_N          (rst_n),
        .STALL            (stall),
        .ID_BRANCH_JUMP   (id_bj),
        .ID_PC            (id_pc),
        .ID_TARGET        (id_tgt),
        .EX_BRANCH_JUMP   (ex_bj),
        .EX_PC            (ex_pc),
        .EX_TARGET        (ex_tgt),
        .EX_PRED_TAKEN    (ex_pred),
        .EX_PC_SEL        (ex_sel),
        .ID_PRED_TAKEN    (id_pred_taken),
        .REDIRECT         (redirect),
        .REDIRECT_PC      (redirect_pc),
        .FLUSH_IF_ID      (flush_if_id),
        .FLUSH_ID_EX      (flush_id_ex),
        .BRANCH_COUNT     (branch_count),
        .MISPREDICT_COUNT (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        bcnt_m = 32'd0;
        mcnt_m = 32'd0;
    endtask

    task automatic drive_idle();
        stall   = 1'b0;
        id_bj   = BJ_NO;
        id_pc   = 32'd0;
        id_tgt  = 32'd0;
        ex_bj   = BJ_NO;
        ex_pc   = 32'd0;
        ex_tgt  = 32'd0;
        ex_pred = 1'b0;
        ex_sel  = 1'b0;
    endtask

    // One pipeline cycle: apply inputs, check outputs against the model,
    // then advance the model as the coming clock edge will.
    task automatic txn(input logic [2:0] ibj, input logic [31:0] ipc, input logic [31:0] itgt,
                       input logic [2:0] ebj, input logic [31:0] epc, input logic [31:0] etgt,
                       input logic ep, input logic es, input logic st);
        logic        exp_pred, mis, exp_redir, exp_fif, exp_fie;
        logic [31:0] exp_rpc;
        bit          icond, econd;
        int          ei;
        @(negedge clk);
        id_bj = ibj; id_pc = ipc; id_tgt = itgt;
        ex_bj = ebj; ex_pc = epc; ex_tgt = etgt;
        ex_pred = ep; ex_sel = es; stall = st;
        #1;
        icond    = (ibj != 3'd0) && (ibj != 3'd1);
        econd    = (ebj != 3'd0) && (ebj != 3'd1);
        exp_pred = (ibj == 3'd1) || (icond && bht_m[ipc[7:2]] >= 2);
        mis      = (ebj != 3'd0) && (ep != es);
        exp_redir = mis || exp_pred;
        exp_fif   = exp_redir;
        exp_fie   = mis;
        exp_rpc   = mis ? (es ? etgt : epc + 32'd4) : itgt;
        chk("id_pred_taken", {31'd0, id_pred_taken}, {31'd0, exp_pred});
        chk("redirect", {31'd0, redirect}, {31'd0, exp_redir});
        if (exp_redir) chk("redirect_pc", redirect_pc, exp_rpc);
        chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, exp_fif});
        chk("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, exp_fie});
        chk("branch_count", branch_count, bcnt_m);
        chk("mispredict_count", mispredict_count, mcnt_m);
        $display("txn %0d: st=%0b id=%0d@%h ex=%0d@%h p/s=%0b%0b pred=%0b redir=%0b rpc=%h fl=%0b%0b bc=%0d mc=%0d",
                 n_txn, st, ibj, ipc, ebj, epc, ep, es, id_pred_taken, redirect, redirect_pc,
                 flush_if_id, flush_id_ex, branch_count, mispredict_count);
        n_txn++;
        if (!st) begin
            if (ebj != 3'd0) bcnt_m = bcnt_m + 32'd1;
            if (mis) mcnt_m = mcnt_m + 32'd1;
            if (econd) begin
                ei = int'(epc[7:2]);
                if (es) bht_m[ei] = (bht_m[ei] == 3) ? 3 : bht_m[ei] + 1;
                else    bht_m[ei] = (bht_m[ei] == 0) ? 0 : bht_m[ei] - 1;
            end
        end
    endtask

    // Asynchronous reset pulse away from the clock edge.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        drive_idle();
        #1;
        chk("rst_branch_count", branch_count, 32'd0);
        chk("rst_mispredict_count", mispredict_count, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
        chk("rst_pred", {31'd0, id_pred_taken}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 1) == 0) return 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
        return {$urandom, 2'b00} >> 0 & 32'hFFFF_FFFC;
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_txn    = 0;
        rst_n    = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        pulse_reset();

        // Fresh table: BEQ at 0x40 sits at WNT and predicts not taken.
        txn(BJ_BEQ, 32'h40, 32'h80, BJ_NO, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_beq_pred", {31'd0, id_pred_taken}, 32'd0);

        // Two taken BNE resolutions at 0x100 move WNT to ST.
        repeat (2) txn(BJ_NO, 32'h0, 32'h0, BJ_BNE, 32'h100, 32'h180, 1'b0, 1'b1, 1'b0);
        txn(BJ_BNE, 32'h100, 32'h180, BJ_NO, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("train_pred", {31'd0, id_pred_taken}, 32'd1);
        chk("train_rpc", redirect_pc, 32'h180);
        chk("train_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd2);

        // Predicted-taken BLT that falls through.
        txn(BJ_NO, 32'h0, 32'h0, BJ_BLT, 32'h200, 32'h240, 1'b1, 1'b0, 1'b0);
        chk("mis_nt_rpc", redirect_pc, 32'h204);
        chk("mis_nt_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);

        // EX mispredict outranks an ID jump.
        txn(BJ_J, 32'h400, 32'h500, BJ_BEQ, 32'h280, 32'h300, 1'b0, 1'b1, 1'b0);
        chk("prio_rpc", redirect_pc, 32'h300);
        chk("prio_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);

        // Stalled BGEU trains exactly once.
        repeat (3) begin
            txn(BJ_NO, 32'h0, 32'h0, BJ_BGEU, 32'h3C0, 32'h3F0, 1'b0, 1'b1, 1'b1);
            chk("stall_rpc", redirect_pc, 32'h3F0);
        end
        txn(BJ_NO, 32'h0, 32'h0, BJ_BGEU, 32'h3C0, 32'h3F0, 1'b0, 1'b1, 1'b0);
        txn(BJ_BGEU, 32'h3C0, 32'h3F0, BJ_NO, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("stall_once_taken", {31'd0, id_pred_taken}, 32'd1);
        txn(BJ_NO, 32'h0, 32'h0, BJ_BGEU, 32'h3C0, 32'h3F0, 1'b1, 1'b0, 1'b0);
        txn(BJ_BGEU, 32'h3C0, 32'h3F0, BJ_NO, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("stall_once_back", {31'd0, id_pred_taken}, 32'd0);

        // Saturation at both ends of the counter range.
        repeat (5) txn(BJ_NO, 32'h0, 32'h0, BJ_BEQ, 32'h80, 32'hC0, 1'b1, 1'b1, 1'b0);
        txn(BJ_NO, 32'h0, 32'h0, BJ_BEQ, 32'h80, 32'hC0, 1'b0, 1'b0, 1'b0);
        txn(BJ_BEQ, 32'h80, 32'hC0, BJ_NO, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("sat_high", {31'd0, id_pred_taken}, 32'd1);
        repeat (4) txn(BJ_NO, 32'h0, 32'h0, BJ_BEQ, 32'h80, 32'hC0, 1'b0, 1'b0, 1'b0);
        txn(BJ_NO, 32'h0, 32'h0, BJ_BEQ, 32'h80, 32'hC0, 1'b0, 1'b1, 1'b0);
        txn(BJ_BEQ, 32'h80, 32'hC0, BJ_NO, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("sat_low", {31'd0, id_pred_taken}, 32'd0);

        // EX_PC + 4 wraps at the top of the address space.
        txn(BJ_NO, 32'h0, 32'h0, BJ_BNE, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b0, 1'b0);
        chk("wrap_rpc", redirect_pc, 32'h0);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) pulse_reset();
            txn(3'($urandom_range(0, 7)), rand_pc(), $urandom,
                3'($urandom_range(0, 7)), rand_pc(), $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Branch prediction and PC-redirect controller for the 5-stage core.
- **ID stage:** predicts each branch/jump using a bimodal branch history table (BHT) of 2-bit saturating counters.
- **EX stage:** compares the prediction with the resolved outcome (`PC_SEL` from `bj_detect`), drives the PC-redirect mux and the pipeline flush signals, and trains the BHT.
- **Software visibility:** keeps branch and mispredict counters.

## Interface
Parameters:
- `IDX_BITS`, 6, log2 of BHT entries. BHT index = `PC[IDX_BITS+1:2]`.

Ports:
- `CLK`  in  1  core clock. One clock domain; reset is asynchronous and active-low.
- `RESET_N`  in  1  asynchronous active-low reset.
- `STALL`  in  1  pipeline freeze; ID/EX contents hold.
- `ID_BRANCH_JUMP`  in  3  decoded branch/jump type in ID (`NO`, `J`, `BEQ`, `BNE`, `BLT`, `BGE`, `BLTU`, `BGEU`).
- `ID_PC`, `ID_TARGET`  in  32  PC and computed target of the ID instruction.
- `EX_BRANCH_JUMP`  in  3  type of the EX instruction.
- `EX_PC`, `EX_TARGET`  in  32  PC and target of the EX instruction.
- `EX_PRED_TAKEN`  in  1  `ID_PRED_TAKEN` carried through the ID/EX register.
- `EX_PC_SEL`  in  1  resolved outcome from `bj_detect`.
- `ID_PRED_TAKEN`  out  1  prediction for the ID instruction.
- `REDIRECT`  out  1  PC mux select for the redirect path.
- `REDIRECT_PC`  out  32  next fetch PC when `REDIRECT` = 1.
- `FLUSH_IF_ID`, `FLUSH_ID_EX`  out  1  bubble insertion: the flushed stage gets type `NO`.
- `BRANCH_COUNT`, `MISPREDICT_COUNT`  out  32  performance counters.

## Operation
**Prediction (ID):**
- `J` → taken.
- Conditional branch → taken if BHT counter bit[1] = 1.
- `NO` → not taken.

**Resolution (EX), mispredict condition:**
- Mispredict = `EX_BRANCH_JUMP` ≠ `NO` and `EX_PRED_TAKEN` ≠ `EX_PC_SEL`.
- On mispredict: `REDIRECT` = 1, `FLUSH_IF_ID` = `FLUSH_ID_EX` = 1.
- `REDIRECT_PC` = `EX_TARGET` if `EX_PC_SEL` = 1, else `EX_PC` + 4 (mod 2^32).

**Predicted-taken in ID, no EX mispredict:**
- `REDIRECT` = 1, `REDIRECT_PC` = `ID_TARGET`.
- `FLUSH_IF_ID` = 1, `FLUSH_ID_EX` = 0.

**Priority:**
- An EX mispredict overrides any ID prediction redirect (EX is the older instruction).
- The ID instruction is flushed in that case.

**BHT training:**
- Trained on conditional branches in EX only, when `STALL` = 0.
- Taken → increment, saturating at 3. Not taken → decrement, saturating at 0.
- `J` and `NO` never write.
- Counter encoding: 0 = strongly not taken (SNT), 1 = weakly not taken (WNT), 2 = weakly taken (WT), 3 = strongly taken (ST).

**Performance counters** (both update only when `STALL` = 0, wrap mod 2^32):
- `BRANCH_COUNT` +1 per EX instruction with type ≠ `NO`.
- `MISPREDICT_COUNT` +1 per mispredict.

**During `STALL`:**
- Redirect/flush outputs stay combinationally valid.
- No BHT or counter update, so a stalled branch trains exactly once.

**Same-cycle BHT read and write, same index:** ID reads the pre-update value (read-old).

## Timing
- Reset (async, `RESET_N` low):
  - All BHT entries = WNT (1).
  - Both counters = 0.
  - All control outputs 0 while reset is asserted, since EX/ID types are `NO` after pipeline reset.
- Prediction and redirect/flush outputs are combinational, with zero-cycle latency from ID/EX inputs.
- BHT and counter updates take effect at the `CLK` rising edge after resolution; the earliest visible read is the next cycle.
- Mispredict penalty: 2 cycles (IF and ID squashed). Predicted-taken penalty: 1 cycle.
- Reset mid-operation: all state is cleared immediately; there is no partial training.

## Structure
- Add to `encodings.v`: `SNT`/`WNT`/`WT`/`ST` counter constants and a `BHT_RESET` value (= `WNT`).
- Branch type codes come from the existing `encodings.v`.
- One sub-module, `bht`: a 2^`IDX_BITS` × 2-bit flop array with async clear, one combinational read port, and one saturating-update write port.
- Expected RTL size: about 250 lines total.

## Test plan
- **Reset:** assert `RESET_N` = 0 mid-run, then release → BHT entry for PC 0x40 reads WNT; `ID_PRED_TAKEN` = 0 for a `BEQ` at 0x40; both counters = 0.
- **Training:** a `BNE` at PC 0x100 resolves taken twice (`STALL` = 0) → next ID `BNE` at 0x100 gives `ID_PRED_TAKEN` = 1 and `REDIRECT_PC` = `ID_TARGET` (0x180); `FLUSH_IF_ID` = 1 only.
- **Mispredict, not taken:** EX `BLT`, `EX_PRED_TAKEN` = 1, `EX_PC_SEL` = 0, `EX_PC` = 0x200 → `REDIRECT_PC` = 0x204; both flushes = 1; `MISPREDICT_COUNT` +1.
- **Priority:** EX mispredict (`EX_TARGET` 0x300, taken) in the same cycle as an ID `J` to 0x500 → `REDIRECT_PC` = 0x300; both flushes = 1.
- **Stall:** EX `BGEU` taken with `STALL` = 1 for 3 cycles → outputs held; the counter for that index moves by exactly 1 after `STALL` drops; `BRANCH_COUNT` +1.
- **Saturation:** 5 taken resolutions at one index → counter = 3; 5 not taken → counter = 0, with no wrap.
